// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the Kyber NTT/INTT sequencer: butterfly mode
// encodings, FSM states, delay-line entry layout and ring dimensions.
package ntt_ctrl_pkg;

   localparam int N       = 256;
   localparam int NLAYERS = 7;
   localparam int COEF_W  = 16;

   localparam logic [1:0] BF_NTT    = 2'b00;
   localparam logic [1:0] BF_INTT   = 2'b01;
   localparam logic [1:0] BF_BYPASS = 2'b10;
   localparam logic [1:0] BF_IDLE   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   // One slot of the read-to-write delay line.
   typedef struct packed {
      logic       valid;
      logic [7:0] a;
      logic [7:0] b;
   } dly_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational pair/twiddle address mapping for one butterfly issue.
// Forward: Cooley-Tukey, span shrinking 128 -> 2.
// Inverse: Gentleman-Sande, span growing 2 -> 128, twiddle index descending.
module ntt_addr_gen (
   input  logic       inv,
   input  logic [2:0] l,
   input  logic [6:0] j,
   output logic [7:0] a,
   output logic [7:0] b,
   output logic [6:0] k
);

   logic [7:0] len;
   logic [7:0] g;
   logic [7:0] o;
   logic [7:0] a_w;

   // Group/offset decomposition of the pair index for the selected transform.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      len = '0;
      g   = '0;
      o   = '0;
      a_w = '0;
      k   = '0;
      if (!inv) begin
         len = 8'd128 >> l;
         g   = {1'b0, j} >> (3'd7 - l);
         o   = {1'b0, j} & (len - 8'd1);
         a_w = (g << (4'd8 - {1'b0, l})) | o;
         k   = 7'((8'd1 << l) + g);
      end else begin
         len = 8'd2 << l;
         g   = {1'b0, j} >> ({1'b0, l} + 4'd1);
         o   = {1'b0, j} & (len - 8'd1);
         a_w = (g << ({1'b0, l} + 4'd2)) | o;
         k   = 7'((8'd128 >> l) - 8'd1 - g);
      end
   end

   assign a = a_w;
   assign b = a_w + len;

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT/INTT sequencer around a single butterfly unit (n=256, q=3329).
// Issues one coefficient pair per cycle for 128 cycles per layer, drains the
// RAM+butterfly pipeline between layers, and replays the read addresses as
// write-back addresses PIPE cycles later.
// Optional feature: define NTT_CTRL_CYCLE_CNT_EN to add the cycle_cnt output.
module ntt_ctrl
   import ntt_ctrl_pkg::*;
#(
   parameter int BF_LAT  = 4,
   parameter int RAM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        inv,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [7:0]  rd_addr_a,
   output logic [7:0]  rd_addr_b,
   output logic [7:0]  tw_addr,
   output logic [1:0]  bf_mode,
   output logic        wr_en,
   output logic [7:0]  wr_addr_a,
   output logic [7:0]  wr_addr_b
`ifdef NTT_CTRL_CYCLE_CNT_EN
   ,
   output logic [15:0] cycle_cnt
`endif
);

   localparam int PIPE = RAM_LAT + BF_LAT;
   localparam int DCW  = $clog2(PIPE + 1);

   state_t           state;
   logic             inv_r;
   logic [2:0]       l;
   logic [6:0]       j;
   logic [DCW-1:0]   drain_cnt;

   logic             gen_inv;
   logic [2:0]       gen_l;
   logic [6:0]       gen_j;
   logic [7:0]       gen_a;
   logic [7:0]       gen_b;
   logic [6:0]       gen_k;

   dly_t             dly [PIPE];

   // Select the pair that will be on the read port in the next cycle.
   always_comb begin
      gen_inv = inv_r;
      gen_l   = l;
      gen_j   = j + 7'd1;
      case (state)
         S_IDLE: begin
            gen_inv = inv;
            gen_l   = '0;
            gen_j   = '0;
         end
         S_DRAIN: begin
            gen_l = l + 3'd1;
            gen_j = '0;
         end
         default: ;
      endcase
   end

   ntt_addr_gen u_addr_gen (
      .inv (gen_inv),
      .l   (gen_l),
      .j   (gen_j),
      .a   (gen_a),
      .b   (gen_b),
      .k   (gen_k)
   );

   // Control FSM with registered read-side outputs.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state     <= S_IDLE;
         inv_r     <= 1'b0;
         l         <= '0;
         j         <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
         bf_mode   <= BF_IDLE;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  inv_r     <= inv;
                  l         <= '0;
                  j         <= '0;
                  busy      <= 1'b1;
                  bf_mode   <= {1'b0, inv};
                  rd_en     <= 1'b1;
                  rd_addr_a <= gen_a;
                  rd_addr_b <= gen_b;
                  tw_addr   <= {gen_inv, gen_k};
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (j == 7'd127) begin
                  rd_en     <= 1'b0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else begin
                  j         <= gen_j;
                  rd_en     <= 1'b1;
                  rd_addr_a <= gen_a;
                  rd_addr_b <= gen_b;
                  tw_addr   <= {gen_inv, gen_k};
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DCW'(PIPE - 1)) begin
                  if (l == 3'(NLAYERS - 1)) begin
                     done    <= 1'b1;
                     bf_mode <= BF_IDLE;
                     state   <= S_DONE;
                  end else begin
                     l         <= gen_l;
                     j         <= gen_j;
                     rd_en     <= 1'b1;
                     rd_addr_a <= gen_a;
                     rd_addr_b <= gen_b;
                     tw_addr   <= {gen_inv, gen_k};
                     state     <= S_ISSUE;
                  end
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read-to-write delay line matching RAM plus butterfly latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this small shift register is cleared on reset (unlike a data
         // RAM) because in-flight valid bits must not produce writes after an abort.
         for (int i = 0; i < PIPE; i++) dly[i] <= '0;
      end else begin
         dly[0] <= '{valid: rd_en, a: rd_addr_a, b: rd_addr_b};
         for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
      end
   end

   assign wr_en     = dly[PIPE-1].valid;
   assign wr_addr_a = dly[PIPE-1].a;
   assign wr_addr_b = dly[PIPE-1].b;

`ifdef NTT_CTRL_CYCLE_CNT_EN
   // Operation length counter, held after completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else if (state == S_IDLE && start) begin
         cycle_cnt <= '0;
      end else if (busy) begin
         cycle_cnt <= cycle_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: randomized operation mix compared cycle
// by cycle against a schedule/addressing model computed with plain arithmetic.
module tb_ntt_ctrl;

   localparam int PIPE     = 5;
   localparam int LAYER    = 128 + PIPE;
   localparam int DONE_CYC = 7 * LAYER + 1;

   logic        clk;
   logic        rst;
   logic        start;
   logic        inv;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [7:0]  rd_addr_a;
   logic [7:0]  rd_addr_b;
   logic [7:0]  tw_addr;
   logic [1:0]  bf_mode;
   logic        wr_en;
   logic [7:0]  wr_addr_a;
   logic [7:0]  wr_addr_b;
`ifdef NTT_CTRL_CYCLE_CNT_EN
   logic [15:0] cycle_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   ntt_ctrl #(.BF_LAT(4), .RAM_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inv       (inv),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_addr   (tw_addr),
      .bf_mode   (bf_mode),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
`ifdef NTT_CTRL_CYCLE_CNT_EN
      ,
      .cycle_cnt (cycle_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Which (layer, pair) is read in run-relative cycle c, if any.
   function automatic bit model_issue(input int c, output int ml, output int mj);
      int t;
      ml = 0;
      mj = 0;
      if (c < 1) return 1'b0;
      t  = c - 1;
      ml = t / LAYER;
      mj = t % LAYER;
      return (ml < 7) && (mj < 128);
   endfunction

   // Butterfly pair and twiddle index: pairs are split into groups of 'half'
   // consecutive pairs, each group covering 2*half coefficients.
   function automatic void model_pair(input bit m_inv, input int ml, input int mj,
                                      output int ma, output int mb, output int mtw);
      int half;
      int grp;
      int k;
      if (!m_inv) begin
         half = 128 / (1 << ml);
         grp  = mj / half;
         k    = (1 << ml) + grp;
      end else begin
         half = 2 * (1 << ml);
         grp  = mj / half;
         k    = 128 / (1 << ml) - 1 - grp;
      end
      ma  = grp * 2 * half + mj % half;
      mb  = ma + half;
      mtw = (m_inv ? 128 : 0) + k;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " rd_en"}, rd_en, 0);
      check({tag, " wr_en"}, wr_en, 0);
      check({tag, " bf_mode"}, bf_mode, 3);
      check({tag, " rd_a"}, rd_addr_a, 0);
      check({tag, " rd_b"}, rd_addr_b, 0);
      check({tag, " tw"}, tw_addr, 0);
      check({tag, " wr_a"}, wr_addr_a, 0);
      check({tag, " wr_b"}, wr_addr_b, 0);
`ifdef NTT_CTRL_CYCLE_CNT_EN
      check({tag, " cycle_cnt"}, cycle_cnt, 0);
`endif
   endtask

   // Called at a negedge with the DUT idle; start is sampled at the next posedge (cycle 0).
   task automatic run_op(input bit inv_i, input int abort_at, input int poke_at);
      int  ml, mj, ma, mb, mtw;
      int  n_wr;
      bit  exp_rd, exp_wr, aborted;
      n_wr    = 0;
      aborted = 1'b0;
      start   = 1'b1;
      inv     = inv_i;
      @(posedge clk);
      #1;
      start = 1'b0;
      inv   = ~inv_i;
      for (int c = 1; c <= DONE_CYC + 1; c++) begin
         @(negedge clk);
         exp_rd = model_issue(c, ml, mj);
         check($sformatf("busy c%0d", c), busy, (c <= DONE_CYC));
         check($sformatf("done c%0d", c), done, (c == DONE_CYC));
         check($sformatf("rd_en c%0d", c), rd_en, exp_rd);
         check($sformatf("bf_mode c%0d", c), bf_mode, (c < DONE_CYC) ? (inv_i ? 1 : 0) : 3);
         if (exp_rd) begin
            model_pair(inv_i, ml, mj, ma, mb, mtw);
            check($sformatf("rd_a c%0d", c), rd_addr_a, ma);
            check($sformatf("rd_b c%0d", c), rd_addr_b, mb);
            check($sformatf("tw c%0d", c), tw_addr, mtw);
         end
         exp_wr = model_issue(c - PIPE, ml, mj);
         check($sformatf("wr_en c%0d", c), wr_en, exp_wr);
         if (wr_en === 1'b1) n_wr++;
         if (exp_wr) begin
            model_pair(inv_i, ml, mj, ma, mb, mtw);
            check($sformatf("wr_a c%0d", c), wr_addr_a, ma);
            check($sformatf("wr_b c%0d", c), wr_addr_b, mb);
         end
`ifdef NTT_CTRL_CYCLE_CNT_EN
         if (c == DONE_CYC + 1) check("cycle_cnt end", cycle_cnt, DONE_CYC);
`endif
         // Stimulus for the next sampling edge.
         start = 1'b0;
         if (c == poke_at) begin
            start = 1'b1;
            inv   = 1'($urandom);
         end
         if (c == DONE_CYC) start = 1'b1;
         if (c == abort_at) begin
            rst     = 1'b1;
            aborted = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge clk);
         check_reset_vals("abort");
         rst = 1'b0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("post-abort wr_en %0d", c), wr_en, 0);
            check($sformatf("post-abort busy %0d", c), busy, 0);
         end
      end else begin
         check("write count", n_wr, 7 * 128);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      inv   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      run_op(1'b0, 0, int'($urandom_range(2, 900)));
      // Chained: start driven in the cycle right after done.
      run_op(1'b1, 0, int'($urandom_range(2, 900)));
      run_op(1'($urandom), 300, int'($urandom_range(2, 290)));
      run_op(1'($urandom), 0, int'($urandom_range(2, 900)));
      run_op(1'($urandom), 0, int'($urandom_range(2, 900)));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
